// File: rtl/cla_arb_pkg.sv
// rtl/cla_arb_pkg.sv - shared types and constants for the shared-adder arbiter
package cla_arb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CLEAR  = 3'd1,
      ST_LOAD_A = 3'd2,
      ST_LOAD_B = 3'd3,
      ST_SUM    = 3'd4,
      ST_RESP   = 3'd5
   } arb_state_t;

   localparam int JOB_CYCLES = 6;

   // Width of a requester index; never below one bit.
   function automatic int idx_width(input int r);
      return (r > 1) ? $clog2(r) : 1;
   endfunction

endpackage

// File: rtl/cla_rr_pick.sv
// rtl/cla_rr_pick.sv - combinational round-robin picker, first set bit at or above ptr
module cla_rr_pick
   import cla_arb_pkg::*;
#(
   parameter int R  = 4,
   parameter int IW = idx_width(R)
) (
   input  logic [R-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          any,
   output logic [IW-1:0] idx
);

   int c;

   // Walk offsets from farthest to nearest so the nearest set bit is assigned last.
   always_comb begin
      any = 1'b0;
      idx = '0;
      c   = 0;
      for (int k = R - 1; k >= 0; k--) begin
         c = (int'(ptr) + k) % R;
         if (req[c]) begin
            any = 1'b1;
            idx = IW'(c);
         end
      end
   end

endmodule

// File: rtl/cla_shared_adder_arbiter.sv
// rtl/cla_shared_adder_arbiter.sv - round-robin sequencer sharing one CLA datapath among R requesters
module cla_shared_adder_arbiter
   import cla_arb_pkg::*;
#(
   parameter  int N  = 16,
   parameter  int R  = 4,
   localparam int IW = idx_width(R)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [R-1:0]   req,
   input  logic [R*N-1:0] req_a,
   input  logic [R*N-1:0] req_b,
   input  logic [R-1:0]   req_cin,
   output logic [R-1:0]   gnt,
   output logic [R-1:0]   done,
   output logic [N:0]     result,
   output logic           busy,
   output logic           dp_clr_a,
   output logic           dp_clr_b,
   output logic           dp_load_a,
   output logic           dp_load_b,
   output logic           dp_carry_in,
   output logic [N-1:0]   dp_data_in,
   input  logic [N:0]     dp_data_out
);

   arb_state_t    state, state_nxt;
   logic [N-1:0]  op_a, op_b;
   logic          op_cin;
   logic [IW-1:0] job_idx, ptr;
   logic [R-1:0]  job_onehot;
   logic          pick_any;
   logic [IW-1:0] pick_idx;

   cla_rr_pick #(.R(R), .IW(IW)) u_pick (
      .req (req),
      .ptr (ptr),
      .any (pick_any),
      .idx (pick_idx)
   );

   assign job_onehot = {{(R-1){1'b0}}, 1'b1} << job_idx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         ptr     <= '0;
         job_idx <= '0;
         op_a    <= '0;
         op_b    <= '0;
         op_cin  <= 1'b0;
         result  <= '0;
      end else begin
         state <= state_nxt;
         if (state == ST_IDLE && pick_any) begin
            job_idx <= pick_idx;
            op_a    <= req_a[int'(pick_idx)*N +: N];
            op_b    <= req_b[int'(pick_idx)*N +: N];
            op_cin  <= req_cin[pick_idx];
         end
         if (state == ST_SUM) begin
            result <= dp_data_out;
         end
         // The served requester drops to lowest priority for the next round.
         if (state == ST_RESP) begin
            ptr <= (int'(job_idx) == R - 1) ? '0 : job_idx + 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt   = state;
      gnt         = '0;
      done        = '0;
      busy        = 1'b1;
      dp_clr_a    = 1'b0;
      dp_clr_b    = 1'b0;
      dp_load_a   = 1'b0;
      dp_load_b   = 1'b0;
      dp_data_in  = '0;
      dp_carry_in = op_cin;
      case (state)
         ST_IDLE: begin
            busy        = 1'b0;
            dp_carry_in = 1'b0;
            if (pick_any) state_nxt = ST_CLEAR;
         end
         ST_CLEAR: begin
            gnt       = job_onehot;
            dp_clr_a  = 1'b1;
            dp_clr_b  = 1'b1;
            state_nxt = ST_LOAD_A;
         end
         ST_LOAD_A: begin
            dp_data_in = op_a;
            dp_load_a  = 1'b1;
            state_nxt  = ST_LOAD_B;
         end
         ST_LOAD_B: begin
            dp_data_in = op_b;
            dp_load_b  = 1'b1;
            state_nxt  = ST_SUM;
         end
         ST_SUM: begin
            state_nxt = ST_RESP;
         end
         ST_RESP: begin
            done      = job_onehot;
            state_nxt = ST_IDLE;
         end
         default: begin
            busy        = 1'b0;
            dp_carry_in = 1'b0;
            state_nxt   = ST_IDLE;
         end
      endcase
   end

endmodule
